// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, port indexing and helpers for the two-port data memory arbiter.
// Port 0 is the CPU load/store path, port 1 the loader/DMA path.
package data_mem_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic port_t gnt_to_port(input logic [NUM_PORTS-1:0] gnt);
    return gnt[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signals of the data memory arbiter.
// The slave view belongs to the arbiter; master is the surrounding environment.
interface data_mem_arbiter_if;
  import data_mem_arb_pkg::*;

  logic              p0_req;
  logic              p1_req;
  logic [BE_W-1:0]   p0_we;
  logic [BE_W-1:0]   p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              p0_rvalid;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;

  logic              ena;
  logic [BE_W-1:0]   wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output douta,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    input  ena, wea, addra, dina
  );

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  douta,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    output ena, wea, addra, dina
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant: a lone requester wins immediately,
// a tie goes to the port that did not win last time.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_t                last_grant,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT0) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU (p0) and the loader (p1).
// Grants are combinational; read data returns one cycle after the grant.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
(
  input  logic                clka,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  port_t                gnt_port;
  port_t                last_grant;
  port_t                rd_port;
  logic                 rd_pending;
  logic                 rd_valid;

  // Reset masks requests so nothing is granted or issued while rst is high.
  assign req = {bus.p1_req, bus.p0_req} & {NUM_PORTS{~rst}};

  rr_arbiter2 u_rr_arbiter2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign gnt_port   = gnt_to_port(gnt);
  assign bus.p0_gnt = gnt[0];
  assign bus.p1_gnt = gnt[1];

  always_comb begin
    bus.ena   = 1'b0;
    bus.wea   = '0;
    bus.addra = '0;
    bus.dina  = '0;
    if (gnt[0]) begin
      bus.ena   = 1'b1;
      bus.wea   = bus.p0_we;
      bus.addra = bus.p0_addr;
      bus.dina  = bus.p0_wdata;
    end else if (gnt[1]) begin
      bus.ena   = 1'b1;
      bus.wea   = bus.p1_we;
      bus.addra = bus.p1_addr;
      bus.dina  = bus.p1_wdata;
    end
  end

  // last_grant resets to PORT1 so the first tie after reset goes to the CPU.
  always_ff @(posedge clka) begin
    if (rst) begin
      last_grant <= PORT1;
      rd_pending <= 1'b0;
      rd_port    <= PORT0;
    end else begin
      rd_pending <= (|gnt) && (bus.wea == '0);
      if (|gnt) begin
        last_grant <= gnt_port;
        rd_port    <= gnt_port;
      end
    end
  end

  assign rd_valid = rd_pending & ~rst;

  assign bus.p0_rvalid = rd_valid && (rd_port == PORT0);
  assign bus.p1_rvalid = rd_valid && (rd_port == PORT1);
  assign bus.p0_rdata  = bus.p0_rvalid ? bus.douta : '0;
  assign bus.p1_rdata  = bus.p1_rvalid ? bus.douta : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomised checks of data_mem_arbiter against a write-first
// single-port memory with one-cycle read latency.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  logic clka = 1'b0;
  logic rst;
  logic mem_clear;
  int   checks = 0;
  int   errors = 0;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  logic [DATA_W-1:0] mem    [0:255];
  logic [DATA_W-1:0] shadow [0:255];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] new_d,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  // Memory model: writes commit at the edge, reads return on the next cycle.
  always @(posedge clka) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.ena) begin
      if (bus.wea != '0) begin
        mem[bus.addra[7:0]] <= merge(mem[bus.addra[7:0]], bus.dina, bus.wea);
        bus.douta <= merge(mem[bus.addra[7:0]], bus.dina, bus.wea);
      end else begin
        bus.douta <= mem[bus.addra[7:0]];
      end
    end
  end

  task automatic set_p0(input logic req, input logic [BE_W-1:0] we,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic set_p1(input logic req, input logic [BE_W-1:0] we,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  task automatic idle_ports();
    set_p0(1'b0, '0, '0, '0);
    set_p1(1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    @(negedge clka);
    rst = 1'b1;
    set_p0(1'b1, 4'hF, 32'd5, 32'h1234_5678);
    set_p1(1'b1, 4'h0, 32'd8, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b0) begin errors++; $display("FAIL reset_p0_gnt: got %b expected 0", bus.p0_gnt); end
    checks++; if (bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL reset_p1_gnt: got %b expected 0", bus.p1_gnt); end
    checks++; if (bus.ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b expected 0", bus.ena); end
    checks++; if (bus.wea !== 4'h0) begin errors++; $display("FAIL reset_wea: got %h expected 0", bus.wea); end
    checks++; if (bus.addra !== 32'h0) begin errors++; $display("FAIL reset_addra: got %h expected 0", bus.addra); end
    checks++; if (bus.dina !== 32'h0) begin errors++; $display("FAIL reset_dina: got %h expected 0", bus.dina); end
    checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", bus.p1_rvalid, bus.p0_rvalid); end
    checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.p0_rdata, bus.p1_rdata); end
  endtask

  task automatic test_write_then_read();
    @(negedge clka);
    rst = 1'b0;
    idle_ports();
    set_p1(1'b1, 4'hF, 32'd0, 32'd54);
    #1;
    checks++; if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt: got p0=%b p1=%b expected p0=0 p1=1", bus.p0_gnt, bus.p1_gnt); end
    checks++; if (bus.ena !== 1'b1) begin errors++; $display("FAIL wr_ena: got %b expected 1", bus.ena); end
    checks++; if (bus.wea !== 4'hF) begin errors++; $display("FAIL wr_wea: got %h expected f", bus.wea); end
    checks++; if (bus.addra !== 32'd0 || bus.dina !== 32'd54) begin errors++; $display("FAIL wr_cmd: got addr=%h data=%h expected addr=0 data=36", bus.addra, bus.dina); end

    @(negedge clka);
    set_p1(1'b0, '0, '0, '0);
    set_p0(1'b1, 4'h0, 32'd0, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt: got p0=%b p1=%b expected p0=1 p1=0", bus.p0_gnt, bus.p1_gnt); end
    checks++; if (bus.wea !== 4'h0 || bus.ena !== 1'b1) begin errors++; $display("FAIL rd_cmd: got ena=%b wea=%h expected ena=1 wea=0", bus.ena, bus.wea); end
    checks++; if (bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", bus.p1_rvalid); end

    @(negedge clka);
    idle_ports();
    #1;
    checks++; if (bus.p0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", bus.p0_rvalid); end
    checks++; if (bus.p0_rdata !== 32'd54) begin errors++; $display("FAIL rd_rdata: got %h expected 36", bus.p0_rdata); end
    checks++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0) begin errors++; $display("FAIL rd_other_port: got rvalid=%b rdata=%h expected 0/0", bus.p1_rvalid, bus.p1_rdata); end
    checks++; if (bus.ena !== 1'b0) begin errors++; $display("FAIL rd_idle_ena: got %b expected 0", bus.ena); end
  endtask

  task automatic test_byte_write();
    @(negedge clka);
    set_p0(1'b1, 4'hF, 32'd3, 32'h1122_3344);
    @(negedge clka);
    set_p0(1'b1, 4'b0001, 32'd3, 32'hAABB_CCDD);
    #1;
    checks++; if (bus.wea !== 4'b0001 || bus.dina !== 32'hAABB_CCDD) begin errors++; $display("FAIL be_cmd: got wea=%h dina=%h expected 1/aabbccdd", bus.wea, bus.dina); end
    @(negedge clka);
    set_p0(1'b1, 4'h0, 32'd3, 32'h0);
    @(negedge clka);
    idle_ports();
    #1;
    checks++; if (bus.p0_rvalid !== 1'b1) begin errors++; $display("FAIL be_rvalid: got %b expected 1", bus.p0_rvalid); end
    checks++; if (bus.p0_rdata !== 32'h1122_33DD) begin errors++; $display("FAIL be_rdata: got %h expected 112233dd", bus.p0_rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_p0;
    @(negedge clka);
    set_p0(1'b1, 4'hF, 32'd4, 32'h4444_0000);
    @(negedge clka);
    set_p0(1'b1, 4'hF, 32'd8, 32'h8888_0000);
    @(negedge clka);
    rst = 1'b1;
    idle_ports();
    for (int k = 0; k < 4; k++) begin
      @(negedge clka);
      rst = 1'b0;
      set_p0(1'b1, 4'h0, 32'd4, 32'h0);
      set_p1(1'b1, 4'h0, 32'd8, 32'h0);
      #1;
      exp_p0 = (k % 2 == 0);
      checks++; if (bus.p0_gnt !== exp_p0 || bus.p1_gnt !== !exp_p0) begin errors++; $display("FAIL b2b_gnt[%0d]: got p0=%b p1=%b expected p0=%b", k, bus.p0_gnt, bus.p1_gnt, exp_p0); end
      checks++; if (bus.ena !== 1'b1 || bus.addra !== (exp_p0 ? 32'd4 : 32'd8)) begin errors++; $display("FAIL b2b_cmd[%0d]: got ena=%b addr=%h", k, bus.ena, bus.addra); end
      if (k > 0) begin
        checks++; if (bus.p0_rvalid !== !exp_p0 || bus.p1_rvalid !== exp_p0) begin errors++; $display("FAIL b2b_rvalid[%0d]: got p0=%b p1=%b expected p0=%b", k, bus.p0_rvalid, bus.p1_rvalid, !exp_p0); end
        checks++;
        if (exp_p0 ? (bus.p1_rdata !== 32'h8888_0000) : (bus.p0_rdata !== 32'h4444_0000)) begin
          errors++; $display("FAIL b2b_rdata[%0d]: got p0=%h p1=%h", k, bus.p0_rdata, bus.p1_rdata);
        end
      end
    end
    @(negedge clka);
    idle_ports();
    #1;
    checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'h8888_0000 || bus.p0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_last: got p1_rvalid=%b p1_rdata=%h p0_rvalid=%b expected 1/88880000/0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clka);
    set_p0(1'b1, 4'h0, 32'd3, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1) begin errors++; $display("FAIL rmr_pre_gnt: got %b expected 1", bus.p0_gnt); end
    @(negedge clka);
    rst = 1'b1;
    #1;
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_in_reset: got gnt=%b rvalid=%b expected 0/0", bus.p0_gnt, bus.p0_rvalid); end
    @(negedge clka);
    rst = 1'b0;
    set_p1(1'b1, 4'h0, 32'd4, 32'h0);
    #1;
    checks++; if (bus.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_no_rvalid: got %b expected 0", bus.p0_rvalid); end
    checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL rmr_first_tie: got p0=%b p1=%b expected p0=1 p1=0", bus.p0_gnt, bus.p1_gnt); end
    @(negedge clka);
    idle_ports();
    #1;
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h1122_33DD) begin errors++; $display("FAIL rmr_after: got rvalid=%b rdata=%h expected 1/112233dd", bus.p0_rvalid, bus.p0_rdata); end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clka);
      idle_ports();
      #1;
      checks++; if (bus.ena !== 1'b0 || bus.wea !== 4'h0) begin errors++; $display("FAIL idle_cmd[%0d]: got ena=%b wea=%h expected 0/0", k, bus.ena, bus.wea); end
      checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt[%0d]: got %b%b expected 00", k, bus.p1_gnt, bus.p0_gnt); end
      checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin errors++; $display("FAIL idle_read[%0d]: got rvalid=%b%b rdata=%h/%h expected 0", k, bus.p1_rvalid, bus.p0_rvalid, bus.p0_rdata, bus.p1_rdata); end
    end
  endtask

  task automatic test_random();
    logic              req_s   [2];
    logic [BE_W-1:0]   we_s    [2];
    logic [ADDR_W-1:0] addr_s  [2];
    logic [DATA_W-1:0] wdata_s [2];
    logic              exp_rv  [2];
    logic [DATA_W-1:0] exp_rd  [2];
    logic              g       [2];
    logic              rv      [2];
    logic [DATA_W-1:0] rd      [2];
    int                waits   [2];
    int                p;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = '0; addr_s[i] = '0; wdata_s[i] = '0;
      exp_rv[i] = 1'b0; exp_rd[i] = '0; waits[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clka);
      set_p0(req_s[0], we_s[0], addr_s[0], wdata_s[0]);
      set_p1(req_s[1], we_s[1], addr_s[1], wdata_s[1]);
      #1;
      g[0] = bus.p0_gnt;     g[1] = bus.p1_gnt;
      rv[0] = bus.p0_rvalid; rv[1] = bus.p1_rvalid;
      rd[0] = bus.p0_rdata;  rd[1] = bus.p1_rdata;
      checks++; if (g[0] === 1'b1 && g[1] === 1'b1) begin errors++; $display("FAIL rnd_onehot @%0d: got gnt=11 expected at most one", cyc); end
      checks++; if ((g[0] && !req_s[0]) || (g[1] && !req_s[1])) begin errors++; $display("FAIL rnd_spurious_gnt @%0d: got gnt=%b%b req=%b%b", cyc, g[1], g[0], req_s[1], req_s[0]); end
      checks++; if (bus.ena !== (req_s[0] | req_s[1])) begin errors++; $display("FAIL rnd_ena @%0d: got %b expected %b", cyc, bus.ena, req_s[0] | req_s[1]); end
      for (int i = 0; i < 2; i++) begin
        checks++; if (rv[i] !== exp_rv[i]) begin errors++; $display("FAIL rnd_rvalid%0d @%0d: got %b expected %b", i, cyc, rv[i], exp_rv[i]); end
        checks++; if (rd[i] !== exp_rd[i]) begin errors++; $display("FAIL rnd_rdata%0d @%0d: got %h expected %h", i, cyc, rd[i], exp_rd[i]); end
      end
      for (int i = 0; i < 2; i++) begin exp_rv[i] = 1'b0; exp_rd[i] = '0; end
      if (g[0] === 1'b1 || g[1] === 1'b1) begin
        p = (g[1] === 1'b1) ? 1 : 0;
        checks++;
        if (bus.wea !== we_s[p] || bus.addra !== addr_s[p] || bus.dina !== wdata_s[p]) begin
          errors++; $display("FAIL rnd_cmd @%0d: got we=%h addr=%h data=%h expected %h/%h/%h", cyc, bus.wea, bus.addra, bus.dina, we_s[p], addr_s[p], wdata_s[p]);
        end
        if (we_s[p] == '0) begin
          exp_rv[p] = 1'b1;
          exp_rd[p] = shadow[addr_s[p][7:0]];
        end else begin
          shadow[addr_s[p][7:0]] = merge(shadow[addr_s[p][7:0]], wdata_s[p], we_s[p]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_s[i] && g[i] !== 1'b1) begin
          waits[i]++;
          checks++; if (waits[i] > 1) begin errors++; $display("FAIL rnd_starve%0d @%0d: got %0d waiting cycles expected at most 1", i, cyc, waits[i]); end
        end else begin
          waits[i] = 0;
        end
        if (!req_s[i] || g[i] === 1'b1) begin
          req_s[i]   = ($urandom_range(0, 3) != 0);
          we_s[i]    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          addr_s[i]  = 32'($urandom_range(0, 15));
          wdata_s[i] = $urandom;
        end
      end
    end
    @(negedge clka);
    idle_ports();
  endtask

  initial begin
    rst       = 1'b1;
    mem_clear = 1'b1;
    idle_ports();
    repeat (2) @(negedge clka);
    mem_clear = 1'b0;
    test_reset();
    test_write_then_read();
    test_byte_write();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
